// File: rtl/adler32_pkg.sv
// Shared constants, FSM state type and modulo helper for the parallel Adler-32 engine.
package adler32_pkg;

  localparam logic [15:0] ADLER_MOD  = 16'd65521;
  localparam logic [31:0] ADLER_INIT = 32'h0000_0001;

  // Stage-1 sum widths, sized for the widest legal beat (8 bytes).
  localparam int SA_W = 12;
  localparam int WB_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } adler_state_e;

  // 2^16 mod 65521 = 15, so hi*15+lo preserves the residue; two folds bring
  // any 20-bit operand below 2*65521, one subtract finishes the reduction.
  function automatic logic [15:0] mod65521_fold(input logic [19:0] x);
    logic [16:0] f1;
    logic [15:0] f2;
    f1 = ({13'd0, x[19:16]} * 17'd15) + {1'b0, x[15:0]};
    f2 = (f1[16] ? 16'd15 : 16'd0) + f1[15:0];
    return (f2 >= ADLER_MOD) ? (f2 - ADLER_MOD) : f2;
  endfunction

endpackage

// File: rtl/adler32_par_if.sv
// Beat/handshake bundle for adler32_par; master drives the stream, slave is the engine.
interface adler32_par_if #(
  parameter int DATA_WD = 32
) ();
  localparam int NBYTE = DATA_WD / 8;
  localparam int CW    = $clog2(NBYTE + 1);

  logic               start_i;
  logic               val_i;
  logic [DATA_WD-1:0] dat_i;
  logic               lst_i;
  logic [CW-1:0]      bcnt_i;
  logic               rdy_o;
  logic               done_o;
  logic               val_o;
  logic [31:0]        dat_o;

  modport master (
    output start_i, val_i, dat_i, lst_i, bcnt_i,
    input  rdy_o, done_o, val_o, dat_o
  );

  modport slave (
    input  start_i, val_i, dat_i, lst_i, bcnt_i,
    output rdy_o, done_o, val_o, dat_o
  );
endinterface

// File: rtl/adler32_lane_sum.sv
// Stage 1: per-beat byte sum and position-weighted sum over NBYTE lanes, registered.
module adler32_lane_sum
  import adler32_pkg::*;
#(
  parameter int NBYTE = 4,
  parameter int CW    = 3
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               clr_i,
  input  logic               vld_i,
  input  logic [8*NBYTE-1:0] dat_i,
  input  logic [CW-1:0]      n_i,
  output logic               vld_o,
  output logic [CW-1:0]      n_o,
  output logic [SA_W-1:0]    sa_o,
  output logic [WB_W-1:0]    wb_o
);

  logic [SA_W-1:0] sa_d, sa_q;
  logic [WB_W-1:0] wb_d, wb_q;
  logic [CW-1:0]   n_q;
  logic            vld_q;
  logic [7:0]      lane;

  // Lane 0 is the MSB byte, i.e. the first byte in stream order; it is
  // weighted n, the last valid byte is weighted 1.
  always_comb begin
    sa_d = '0;
    wb_d = '0;
    lane = '0;
    for (int k = 0; k < NBYTE; k++) begin
      lane = dat_i[8*(NBYTE-k)-1 -: 8];
      if (k < int'(n_i)) begin
        sa_d = sa_d + SA_W'(lane);
        wb_d = wb_d + WB_W'((int'(n_i) - k) * int'(lane));
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_q <= 1'b0;
      n_q   <= '0;
      sa_q  <= '0;
      wb_q  <= '0;
    end else if (clr_i) begin
      vld_q <= 1'b0;
    end else begin
      vld_q <= vld_i;
      if (vld_i) begin
        n_q  <= n_i;
        sa_q <= sa_d;
        wb_q <= wb_d;
      end
    end
  end

  assign vld_o = vld_q;
  assign n_o   = n_q;
  assign sa_o  = sa_q;
  assign wb_o  = wb_q;

endmodule

// File: rtl/adler32_par.sv
// Parallel Adler-32 engine, NBYTE bytes per beat, final {B,A} on done_o.
// Build option ADLER32_RUNNING_EN: val_o/dat_o report the running checksum after every beat.
//
// state    | meaning
// ---------|-----------------------------------------------
// ST_IDLE  | no stream open, rdy_o low
// ST_RUN   | accepting beats
// ST_FLUSH | last beat accepted, pipeline draining (2 cycles)
// ST_DONE  | A/B final, done_o registered on the next edge
module adler32_par
  import adler32_pkg::*;
#(
  parameter int DATA_WD  = 32,
  parameter int MOD_BASE = 65521
) (
  input logic           clk,
  input logic           rstn,
  adler32_par_if.slave  bus
);

  localparam int NBYTE = DATA_WD / 8;
  localparam int CW    = $clog2(NBYTE + 1);
  localparam logic [16:0] MOD17 = 17'(MOD_BASE);

  adler_state_e state_q, state_d;
  logic         flush_cnt_q, flush_cnt_d;
  logic         done_d;

  logic               beat_vld_q;
  logic [DATA_WD-1:0] beat_dat_q;
  logic [CW-1:0]      beat_n_q;
  logic [15:0]        a_q, b_q;
  logic               done_q, val_q;
  logic [31:0]        dat_q;

  logic               accept;
  logic [CW-1:0]      n_in;
  logic               s1_vld;
  logic [CW-1:0]      s1_n;
  logic [SA_W-1:0]    s1_sa;
  logic [WB_W-1:0]    s1_wb;
  logic [16:0]        sum_a;
  logic [19:0]        sum_b;
  logic [15:0]        a_nxt, b_nxt;

  // A beat offered together with start_i belongs to the aborted stream.
  assign bus.rdy_o = (state_q == ST_RUN) && !bus.start_i;
  assign accept    = bus.val_i && bus.rdy_o;
  assign n_in      = (bus.lst_i && (bus.bcnt_i != '0)) ? bus.bcnt_i : CW'(NBYTE);

  adler32_lane_sum #(.NBYTE(NBYTE), .CW(CW)) u_lane_sum (
    .clk   (clk),
    .rstn  (rstn),
    .clr_i (bus.start_i),
    .vld_i (beat_vld_q),
    .dat_i (beat_dat_q),
    .n_i   (beat_n_q),
    .vld_o (s1_vld),
    .n_o   (s1_n),
    .sa_o  (s1_sa),
    .wb_o  (s1_wb)
  );

  // B uses the A from before this beat: each of the n bytes adds the old A once.
  always_comb begin
    sum_a = {1'b0, a_q} + 17'(s1_sa);
    a_nxt = (sum_a >= MOD17) ? 16'(sum_a - MOD17) : sum_a[15:0];
    sum_b = 20'(b_q) + (20'(s1_n) * 20'(a_q)) + 20'(s1_wb);
    b_nxt = mod65521_fold(sum_b);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      flush_cnt_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE: ;
      ST_RUN: begin
        if (accept && bus.lst_i) begin
          state_d     = ST_FLUSH;
          flush_cnt_d = 1'b1;
        end
      end
      ST_FLUSH: begin
        if (flush_cnt_q == 1'b0) state_d = ST_DONE;
        else                     flush_cnt_d = 1'b0;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    if (bus.start_i) begin
      state_d     = ST_RUN;
      flush_cnt_d = 1'b0;
      done_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      beat_vld_q <= 1'b0;
      beat_dat_q <= '0;
      beat_n_q   <= '0;
      a_q        <= ADLER_INIT[15:0];
      b_q        <= ADLER_INIT[31:16];
      done_q     <= 1'b0;
      val_q      <= 1'b0;
      dat_q      <= ADLER_INIT;
    end else if (bus.start_i) begin
      beat_vld_q <= 1'b0;
      a_q        <= ADLER_INIT[15:0];
      b_q        <= ADLER_INIT[31:16];
      done_q     <= 1'b0;
      val_q      <= 1'b0;
      dat_q      <= ADLER_INIT;
    end else begin
      beat_vld_q <= accept;
      if (accept) begin
        beat_dat_q <= bus.dat_i;
        beat_n_q   <= n_in;
      end
      if (s1_vld) begin
        a_q <= a_nxt;
        b_q <= b_nxt;
      end
      done_q <= done_d;
`ifdef ADLER32_RUNNING_EN
      val_q <= s1_vld;
      if (s1_vld)      dat_q <= {b_nxt, a_nxt};
      else if (done_d) dat_q <= {b_q, a_q};
`else
      val_q <= done_d;
      if (done_d) dat_q <= {b_q, a_q};
`endif
    end
  end

  assign bus.done_o = done_q;
  assign bus.val_o  = val_q;
  assign bus.dat_o  = dat_q;

endmodule
